// File: rtl/trap_ctrl_if.sv
// -----------------------------------------------------------------------------
// trap_ctrl_if
//   CSR-file access port used by the trap/return sequencer.
//
//   Signals
//     csr_addr    12     CSR address presented to the CSR file
//     csr_r_data  MXLEN  combinational read data for csr_addr
//     csr_we      1      CSR write strobe
//     csr_w_data  MXLEN  CSR write data
//
//   Modports
//     master : the sequencer (drives address / write strobe / write data)
//     slave  : the CSR file  (returns read data)
// -----------------------------------------------------------------------------
`ifndef MXLEN
`define MXLEN 32
`endif

interface trap_ctrl_if;
  logic [11:0]         csr_addr;
  logic [`MXLEN-1:0]   csr_r_data;
  logic                csr_we;
  logic [`MXLEN-1:0]   csr_w_data;

  modport master (
    output csr_addr,
    output csr_we,
    output csr_w_data,
    input  csr_r_data
  );

  modport slave (
    input  csr_addr,
    input  csr_we,
    input  csr_w_data,
    output csr_r_data
  );
endinterface

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//   Trap and return sequencer for the single-issue core. Detects exceptions,
//   interrupts and MRET on the instruction in execute, stalls the core while
//   it walks through the required CSR updates over the CSR file's single
//   read/write port, then strobes the PC unit's exception or mret input with
//   the matching target on pc_target.
//
//   Optional feature macro: TRAP_VECTORED_EN
//     defined   : mtvec mode 01 vectors interrupts to base + 4*cause code
//     undefined : target is always the mtvec base, mode bits ignored
//
//   Ports
//     CLK, RST            clock (rising edge), synchronous active-high reset
//     pc_val              PC of the instruction in execute
//     instr_valid         execute holds a valid instruction
//     exc_*               exception flags (decode / PC unit / LSU)
//     exc_tval            faulting address or instruction word
//     mret_req            execute holds MRET
//     irq_ext/sw/timer    pending interrupts, already masked by mie
//     mstatus_mie         global interrupt enable
//     csr                 CSR-file port (trap_ctrl_if.master)
//     pc_target           to PC unit mtvec_or_mepc
//     exception, mret     PC unit load strobes
//     stall               suppresses PC advance and architectural writes
// -----------------------------------------------------------------------------
`ifndef MXLEN
`define MXLEN 32
`endif

module trap_ctrl (
  input  logic                CLK,
  input  logic                RST,

  input  logic [`MXLEN-1:0]   pc_val,
  input  logic                instr_valid,

  input  logic                exc_i_misaligned,
  input  logic                exc_illegal,
  input  logic                exc_ebreak,
  input  logic                exc_ecall,
  input  logic                exc_ld_misaligned,
  input  logic                exc_st_misaligned,
  input  logic [`MXLEN-1:0]   exc_tval,

  input  logic                mret_req,

  input  logic                irq_ext,
  input  logic                irq_sw,
  input  logic                irq_timer,
  input  logic                mstatus_mie,

  trap_ctrl_if.master         csr,

  output logic [`MXLEN-1:0]   pc_target,
  output logic                exception,
  output logic                mret,
  output logic                stall
);

  localparam int unsigned XLEN = `MXLEN;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_CAUSE,
    W_TVAL,
    W_MSTAT,
    T_REDIR,
    M_MSTAT,
    M_REDIR
  } state_e;

  state_e            state_q, state_d;

  logic [XLEN-1:0]   epc_q;
  logic [XLEN-1:0]   cause_q;
  logic [XLEN-1:0]   tval_q;

  logic [11:0]       csr_addr_q;
  logic              csr_we_q;
  logic              exception_q;
  logic              mret_q;

  // ---------------------------------------------------------------------------
  // Event detection (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic              exc_any;
  logic              irq_any;
  logic              ev_window;
  logic              take_exc;
  logic              take_mret;
  logic              take_irq;
  logic              take_trap;

  logic [XLEN-1:0]   ev_epc;
  logic [XLEN-1:0]   ev_cause;
  logic [XLEN-1:0]   ev_tval;

  always_comb begin
    exc_any   = exc_i_misaligned | exc_illegal | exc_ebreak | exc_ecall |
                exc_ld_misaligned | exc_st_misaligned;
    irq_any   = mstatus_mie & (irq_ext | irq_sw | irq_timer);
    ev_window = (state_q == IDLE) & instr_valid;

    // Priority: exceptions, then MRET, then interrupts.
    take_exc  = ev_window & exc_any;
    take_mret = ev_window & ~exc_any & mret_req;
    take_irq  = ev_window & ~exc_any & ~mret_req & irq_any;
    take_trap = take_exc | take_irq;
  end

  always_comb begin
    ev_epc   = pc_val;
    ev_cause = '0;
    ev_tval  = '0;
    if (exc_i_misaligned) begin
      ev_cause = XLEN'(0);
      ev_tval  = exc_tval;
    end else if (exc_illegal) begin
      ev_cause = XLEN'(2);
      ev_tval  = exc_tval;
    end else if (exc_ebreak) begin
      ev_cause = XLEN'(3);
    end else if (exc_ecall) begin
      ev_cause = XLEN'(11);
    end else if (exc_ld_misaligned) begin
      ev_cause = XLEN'(4);
      ev_tval  = exc_tval;
    end else if (exc_st_misaligned) begin
      ev_cause = XLEN'(6);
      ev_tval  = exc_tval;
    end else begin
      // Interrupt: the instruction in execute has not run, and the PC unit
      // adds 4 on return, so pre-bias epc by -4.
      ev_epc = pc_val - XLEN'(4);
      if (irq_ext) begin
        ev_cause = XLEN'(11);
      end else if (irq_sw) begin
        ev_cause = XLEN'(3);
      end else begin
        ev_cause = XLEN'(7);
      end
      ev_cause[XLEN-1] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take_trap) begin
          state_d = W_MEPC;
        end else if (take_mret) begin
          state_d = M_MSTAT;
        end
      end
      W_MEPC:  state_d = W_CAUSE;
      W_CAUSE: state_d = W_TVAL;
      W_TVAL:  state_d = W_MSTAT;
      W_MSTAT: state_d = T_REDIR;
      T_REDIR: state_d = IDLE;
      M_MSTAT: state_d = M_REDIR;
      M_REDIR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe decodes of the state being entered; registered together with the
  // state so the address/strobe outputs come straight from flops.
  function automatic logic [11:0] addr_of(input state_e s);
    unique case (s)
      W_MEPC:  addr_of = CSR_MEPC;
      W_CAUSE: addr_of = CSR_MCAUSE;
      W_TVAL:  addr_of = CSR_MTVAL;
      W_MSTAT: addr_of = CSR_MSTATUS;
      T_REDIR: addr_of = CSR_MTVEC;
      M_MSTAT: addr_of = CSR_MSTATUS;
      M_REDIR: addr_of = CSR_MEPC;
      default: addr_of = '0;
    endcase
  endfunction

  function automatic logic we_of(input state_e s);
    we_of = (s == W_MEPC) || (s == W_CAUSE) || (s == W_TVAL) ||
            (s == W_MSTAT) || (s == M_MSTAT);
  endfunction

  // ---------------------------------------------------------------------------
  // State, latched trap info and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      epc_q       <= '0;
      cause_q     <= '0;
      tval_q      <= '0;
      csr_addr_q  <= '0;
      csr_we_q    <= 1'b0;
      exception_q <= 1'b0;
      mret_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      csr_addr_q  <= addr_of(state_d);
      csr_we_q    <= we_of(state_d);
      exception_q <= (state_d == T_REDIR);
      mret_q      <= (state_d == M_REDIR);
      if (take_trap) begin
        epc_q   <= ev_epc;
        cause_q <= ev_cause;
        tval_q  <= ev_tval;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CSR write data and PC target (depend on the combinational CSR read)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] mstat_trap;
  logic [XLEN-1:0] mstat_mret;
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] trap_target;

  always_comb begin
    mstat_trap        = csr.csr_r_data;
    mstat_trap[7]     = csr.csr_r_data[3];
    mstat_trap[3]     = 1'b0;
    mstat_trap[12:11] = 2'b11;

    mstat_mret        = csr.csr_r_data;
    mstat_mret[3]     = csr.csr_r_data[7];
    mstat_mret[7]     = 1'b1;
  end

  always_comb begin
    mtvec_base  = {csr.csr_r_data[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    // Vectored only for interrupts in mode 01; modes 10/11 behave as direct.
    if (cause_q[XLEN-1] && (csr.csr_r_data[1:0] == 2'b01)) begin
      trap_target = mtvec_base + {cause_q[XLEN-3:0], 2'b00};
    end else begin
      trap_target = mtvec_base;
    end
`else
    trap_target = mtvec_base;
`endif
  end

  always_comb begin
    csr.csr_w_data = '0;
    unique case (state_q)
      W_MEPC:  csr.csr_w_data = epc_q;
      W_CAUSE: csr.csr_w_data = cause_q;
      W_TVAL:  csr.csr_w_data = tval_q;
      W_MSTAT: csr.csr_w_data = mstat_trap;
      M_MSTAT: csr.csr_w_data = mstat_mret;
      default: csr.csr_w_data = '0;
    endcase
  end

  always_comb begin
    csr.csr_addr = csr_addr_q;
    csr.csr_we   = csr_we_q;
    exception    = exception_q;
    mret         = mret_q;

    pc_target = '0;
    if (exception_q) begin
      pc_target = trap_target;
    end else if (mret_q) begin
      pc_target = csr.csr_r_data;
    end

    // Combinational so the trapping/returning instruction commits nothing.
    stall = (state_q != IDLE) | take_trap | take_mret;
  end

endmodule

// File: tb/tb_trap_ctrl.sv
`ifndef MXLEN
`define MXLEN 32
`endif

module tb_trap_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] pc_val;
  logic        instr_valid;
  logic        exc_i_misaligned, exc_illegal, exc_ebreak, exc_ecall;
  logic        exc_ld_misaligned, exc_st_misaligned;
  logic [31:0] exc_tval;
  logic        mret_req;
  logic        irq_ext, irq_sw, irq_timer, mstatus_mie;
  logic [31:0] pc_target;
  logic        exception, mret, stall;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  trap_ctrl_if bus ();

  trap_ctrl dut (
    .CLK               (CLK),
    .RST               (RST),
    .pc_val            (pc_val),
    .instr_valid       (instr_valid),
    .exc_i_misaligned  (exc_i_misaligned),
    .exc_illegal       (exc_illegal),
    .exc_ebreak        (exc_ebreak),
    .exc_ecall         (exc_ecall),
    .exc_ld_misaligned (exc_ld_misaligned),
    .exc_st_misaligned (exc_st_misaligned),
    .exc_tval          (exc_tval),
    .mret_req          (mret_req),
    .irq_ext           (irq_ext),
    .irq_sw            (irq_sw),
    .irq_timer         (irq_timer),
    .mstatus_mie       (mstatus_mie),
    .csr               (bus.master),
    .pc_target         (pc_target),
    .exception         (exception),
    .mret              (mret),
    .stall             (stall)
  );

  // Minimal CSR file: combinational read, write at clock edge, preload port.
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mtval;
  logic        ld = 1'b0;
  logic [31:0] ld_mstatus, ld_mtvec, ld_mepc;

  always_comb begin
    case (bus.csr_addr)
      12'h300: bus.csr_r_data = m_mstatus;
      12'h305: bus.csr_r_data = m_mtvec;
      12'h341: bus.csr_r_data = m_mepc;
      12'h342: bus.csr_r_data = m_mcause;
      12'h343: bus.csr_r_data = m_mtval;
      default: bus.csr_r_data = '0;
    endcase
  end

  always @(posedge CLK) begin
    if (ld) begin
      m_mstatus <= ld_mstatus;
      m_mtvec   <= ld_mtvec;
      m_mepc    <= ld_mepc;
      m_mcause  <= 32'hFFFF_FFFF;
      m_mtval   <= 32'hFFFF_FFFF;
    end else if (bus.csr_we) begin
      case (bus.csr_addr)
        12'h300: m_mstatus <= bus.csr_w_data;
        12'h305: m_mtvec   <= bus.csr_w_data;
        12'h341: m_mepc    <= bus.csr_w_data;
        12'h342: m_mcause  <= bus.csr_w_data;
        12'h343: m_mtval   <= bus.csr_w_data;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    pc_val = '0; instr_valid = 0; exc_tval = '0; mret_req = 0;
    exc_i_misaligned = 0; exc_illegal = 0; exc_ebreak = 0; exc_ecall = 0;
    exc_ld_misaligned = 0; exc_st_misaligned = 0;
    irq_ext = 0; irq_sw = 0; irq_timer = 0; mstatus_mie = 0;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic preload(input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep);
    ld_mstatus = ms; ld_mtvec = tv; ld_mepc = ep; ld = 1'b1;
    step();
    ld = 1'b0;
  endtask

  // Caller drives the event inputs for cycle T, then calls this.
  task automatic run_trap(input string nm, input logic [31:0] e_epc, input logic [31:0] e_cause,
                          input logic [31:0] e_tval, input logic [31:0] e_tgt,
                          input logic [31:0] e_mstat);
    logic [11:0] a [4];
    logic [31:0] d [4];
    a[0] = 12'h341; a[1] = 12'h342; a[2] = 12'h343; a[3] = 12'h300;
    d[0] = e_epc;   d[1] = e_cause; d[2] = e_tval;  d[3] = e_mstat;
    #1;
    chk({nm, ".T.stall"}, stall, 1);
    chk({nm, ".T.we"}, bus.csr_we, 0);
    chk({nm, ".T.addr"}, 32'(bus.csr_addr), 0);
    step();
    for (int i = 0; i < 4; i++) begin
      // Inputs must be ignored outside IDLE.
      pc_val = 32'hDEAD_0000; exc_tval = 32'h1234_5678; instr_valid = 1;
      mret_req = 1; irq_ext = 1; mstatus_mie = 1; exc_illegal = 1;
      #1;
      chk($sformatf("%s.W%0d.addr", nm, i), 32'(bus.csr_addr), 32'(a[i]));
      chk($sformatf("%s.W%0d.we", nm, i), bus.csr_we, 1);
      chk($sformatf("%s.W%0d.wdata", nm, i), bus.csr_w_data, d[i]);
      chk($sformatf("%s.W%0d.stall", nm, i), stall, 1);
      chk($sformatf("%s.W%0d.exc", nm, i), exception, 0);
      step();
    end
    clear_inputs();
    #1;
    chk({nm, ".R.exc"}, exception, 1);
    chk({nm, ".R.mret"}, mret, 0);
    chk({nm, ".R.target"}, pc_target, e_tgt);
    chk({nm, ".R.addr"}, 32'(bus.csr_addr), 32'h305);
    chk({nm, ".R.we"}, bus.csr_we, 0);
    chk({nm, ".R.stall"}, stall, 1);
    step();
    chk({nm, ".E.stall"}, stall, 0);
    chk({nm, ".E.exc"}, exception, 0);
    chk({nm, ".E.target"}, pc_target, 0);
    chk({nm, ".E.addr"}, 32'(bus.csr_addr), 0);
    chk({nm, ".mepc"}, m_mepc, e_epc);
    chk({nm, ".mcause"}, m_mcause, e_cause);
    chk({nm, ".mtval"}, m_mtval, e_tval);
    chk({nm, ".mstatus"}, m_mstatus, e_mstat);
  endtask

  initial begin
    logic [31:0] irq_tgt;
`ifdef TRAP_VECTORED_EN
    irq_tgt = 32'h0000_031C;
`else
    irq_tgt = 32'h0000_0300;
`endif
    clear_inputs();
    RST = 1'b1;
    step();
    preload(32'h0000_0008, 32'h0000_0200, 32'h0);
    chk("rst.stall", stall, 0);
    chk("rst.exc", exception, 0);
    chk("rst.mret", mret, 0);
    chk("rst.target", pc_target, 0);
    chk("rst.addr", 32'(bus.csr_addr), 0);
    chk("rst.we", bus.csr_we, 0);
    chk("rst.wdata", bus.csr_w_data, 0);
    RST = 1'b0;
    step();

    // Illegal instruction.
    pc_val = 32'h100; exc_illegal = 1; exc_tval = 32'h0000_FFFF; instr_valid = 1;
    run_trap("ill", 32'h100, 32'd2, 32'h0000_FFFF, 32'h200, 32'h0000_1880);

    // ecall beats load-misaligned; tval forced to 0.
    pc_val = 32'h40; exc_ecall = 1; exc_ld_misaligned = 1; exc_tval = 32'hABC; instr_valid = 1;
    run_trap("ecall", 32'h40, 32'd11, 32'h0, 32'h200, 32'h0000_1800);

    // Timer interrupt at pc 0 with mtvec mode 01.
    preload(32'h0000_0008, 32'h0000_0301, 32'h0);
    pc_val = 32'h0; irq_timer = 1; mstatus_mie = 1; instr_valid = 1;
    run_trap("tmr", 32'hFFFF_FFFC, 32'h8000_0007, 32'h0, irq_tgt, 32'h0000_1880);

    // Masked interrupt and invalid-instruction exception: nothing happens.
    irq_ext = 1; mstatus_mie = 0; instr_valid = 1; pc_val = 32'h10;
    #1;
    chk("mask.stall", stall, 0);
    step();
    chk("mask.addr", 32'(bus.csr_addr), 0);
    chk("mask.we", bus.csr_we, 0);
    clear_inputs();
    exc_illegal = 1; instr_valid = 0;
    #1;
    chk("nv.stall", stall, 0);
    step();
    chk("nv.we", bus.csr_we, 0);
    clear_inputs();
    step();

    // MRET.
    preload(32'h0000_0080, 32'h0000_0301, 32'h0000_01FC);
    instr_valid = 1; mret_req = 1; pc_val = 32'h1F8;
    #1;
    chk("mret.T.stall", stall, 1);
    chk("mret.T.we", bus.csr_we, 0);
    step();
    exc_illegal = 1;
    #1;
    chk("mret.M.addr", 32'(bus.csr_addr), 32'h300);
    chk("mret.M.we", bus.csr_we, 1);
    chk("mret.M.wdata", bus.csr_w_data, 32'h88);
    chk("mret.M.stall", stall, 1);
    chk("mret.M.mret", mret, 0);
    step();
    clear_inputs();
    #1;
    chk("mret.R.mret", mret, 1);
    chk("mret.R.exc", exception, 0);
    chk("mret.R.target", pc_target, 32'h1FC);
    chk("mret.R.addr", 32'(bus.csr_addr), 32'h341);
    chk("mret.R.we", bus.csr_we, 0);
    chk("mret.R.stall", stall, 1);
    step();
    chk("mret.E.stall", stall, 0);
    chk("mret.E.mret", mret, 0);
    chk("mret.E.target", pc_target, 0);
    chk("mret.mstatus", m_mstatus, 32'h88);

    // ebreak together with mret_req: exception wins.
    pc_val = 32'h80; exc_ebreak = 1; mret_req = 1; instr_valid = 1;
    run_trap("ebrk", 32'h80, 32'd3, 32'h0, 32'h300, 32'h0000_1880);

    // Reset in the middle of a trap sequence.
    preload(32'h0000_0008, 32'h0000_0200, 32'h0);
    pc_val = 32'h500; exc_st_misaligned = 1; exc_tval = 32'h503; instr_valid = 1;
    #1;
    chk("rst2.T.stall", stall, 1);
    step();
    clear_inputs();
    #1;
    chk("rst2.W0.addr", 32'(bus.csr_addr), 32'h341);
    chk("rst2.W0.we", bus.csr_we, 1);
    step();
    RST = 1'b1;
    #1;
    chk("rst2.W1.addr", 32'(bus.csr_addr), 32'h342);
    step();
    RST = 1'b0;
    #1;
    chk("rst2.stall", stall, 0);
    chk("rst2.addr", 32'(bus.csr_addr), 0);
    chk("rst2.we", bus.csr_we, 0);
    chk("rst2.wdata", bus.csr_w_data, 0);
    chk("rst2.target", pc_target, 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rst2.exc%0d", i), exception, 0);
      step();
    end
    chk("rst2.mepc", m_mepc, 32'h500);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
